br_csr_tag_tracker: RTL

- Return path of the branch/CSR tag free list.
- Records each tag popped from the free list at dispatch, in allocation order.
- Marks a tag done when its branch/CSR op completes; completion may arrive out of order.
- Releases done tags in order at commit, producing the write-enable and data that push them back into the free list.
- Sits between dispatch, the branch/CSR execute unit and the free list; flushed with the free list's clean signal.

---
 rtl/br_csr_tag_tracker_pkg.sv | 24 ++
 rtl/br_csr_tag_tracker_cam.sv | 29 ++
 rtl/br_csr_tag_tracker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/br_csr_tag_tracker_pkg.sv
// ---------------------------------------------------------------------------
// br_csr_tag_tracker_pkg
// Shared constants and types for the branch/CSR tag return path.
//   TAGWIDE        : tag width, identical to the free-list entry width
//   TRKDEEP        : number of tracker entries (power of 2)
//   PTRW           : head/tail pointer width
//   FL_RESET_TAGS  : tags the free list holds after reset/clean
//   trk_entry_t    : one tracker slot {valid, done, tag}
// ---------------------------------------------------------------------------
package br_csr_tag_tracker_pkg;

  localparam int TAGWIDE = 4;
  localparam int TRKDEEP = 4;
  localparam int PTRW    = $clog2(TRKDEEP);

  localparam logic [TAGWIDE-1:0] FL_RESET_TAGS [4] = '{4'd2, 4'd6, 4'd10, 4'd14};

  typedef struct packed {
    logic               valid;
    logic               done;
    logic [TAGWIDE-1:0] tag;
  } trk_entry_t;

endpackage

// File: rtl/br_csr_tag_tracker_cam.sv
// ---------------------------------------------------------------------------
// br_csr_tag_tracker_cam
// Combinational associative compare of a completing tag against every
// tracker slot that is valid at the start of the cycle.
//   cmpl_valid_i : completion strobe (already gated by flush in the parent)
//   cmpl_tag_i   : tag of the completing op
//   valid_i      : per-slot valid bits
//   tags_i       : per-slot tags, slot i at [i*TAGWIDE +: TAGWIDE]
//   match_o      : per-slot hit vector; several slots may hit at once
// ---------------------------------------------------------------------------
module br_csr_tag_tracker_cam
  import br_csr_tag_tracker_pkg::*;
(
  input  logic                       cmpl_valid_i,
  input  logic [TAGWIDE-1:0]         cmpl_tag_i,
  input  logic [TRKDEEP-1:0]         valid_i,
  input  logic [TRKDEEP*TAGWIDE-1:0] tags_i,
  output logic [TRKDEEP-1:0]         match_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < TRKDEEP; i++) begin
      match_o[i] = cmpl_valid_i && valid_i[i] &&
                   (tags_i[i*TAGWIDE +: TAGWIDE] == cmpl_tag_i);
    end
  end

endmodule

// File: rtl/br_csr_tag_tracker.sv
// ---------------------------------------------------------------------------
// br_csr_tag_tracker
// Return path of the branch/CSR tag free list. Tags popped at dispatch are
// recorded in allocation order, marked done on (possibly out-of-order)
// completion, and pushed back to the free list in order at commit.
//   Clk        : clock, all state on posedge
//   Rest       : synchronous active-low reset
//   AllocValid : dispatch took AllocTag from the free list this cycle
//   AllocTag   : tag taken
//   CmplValid  : a branch/CSR op completed, tag CmplTag
//   CommitEn   : commit may retire the oldest branch/CSR op
//   Flush      : pipeline flush (free list clean)
//   RelValid   : registered free-list write enable
//   RelTag     : registered free-list write data
//   TrkFull    : all entries valid
//   TrkEmpty   : no valid entries
//   OvfErr     : sticky, an allocation arrived while full
//
// Handshake: every strobe here is valid-only. AllocValid, CmplValid and
// RelValid each mean "one item transferred this cycle"; there is no ready.
// The free list accepts a write every cycle, and an allocation that finds
// the tracker full is dropped and flagged on OvfErr instead of stalled.
// ---------------------------------------------------------------------------
module br_csr_tag_tracker
  import br_csr_tag_tracker_pkg::*;
(
  input  logic               Clk,
  input  logic               Rest,
  input  logic               AllocValid,
  input  logic [TAGWIDE-1:0] AllocTag,
  input  logic               CmplValid,
  input  logic [TAGWIDE-1:0] CmplTag,
  input  logic               CommitEn,
  input  logic               Flush,
  output logic               RelValid,
  output logic [TAGWIDE-1:0] RelTag,
  output logic               TrkFull,
  output logic               TrkEmpty,
  output logic               OvfErr
);

  localparam logic [PTRW:0] CNT_FULL = (PTRW+1)'(TRKDEEP);

  trk_entry_t               ent_q [TRKDEEP];
  logic [PTRW-1:0]          head_q, tail_q;
  logic [PTRW:0]            count_q, count_d;
  logic                     rel_valid_q;
  logic [TAGWIDE-1:0]       rel_tag_q;
  logic                     ovf_q;

  logic [TRKDEEP-1:0]         valid_vec;
  logic [TRKDEEP*TAGWIDE-1:0] tag_flat;
  logic [TRKDEEP-1:0]         match_vec;
  logic                       alloc_acc, alloc_ovf, rel_go;

  always_comb begin
    valid_vec = '0;
    tag_flat  = '0;
    for (int i = 0; i < TRKDEEP; i++) begin
      valid_vec[i]                    = ent_q[i].valid;
      tag_flat[i*TAGWIDE +: TAGWIDE]  = ent_q[i].tag;
    end
  end

  // Compare uses registered valid bits, so a tag allocated this cycle can
  // never be hit by a same-cycle completion.
  br_csr_tag_tracker_cam u_cam (
    .cmpl_valid_i (CmplValid & ~Flush),
    .cmpl_tag_i   (CmplTag),
    .valid_i      (valid_vec),
    .tags_i       (tag_flat),
    .match_o      (match_vec)
  );

  assign TrkFull  = (count_q == CNT_FULL);
  assign TrkEmpty = (count_q == '0);

  // Fullness is judged on the current count: a release in the same cycle
  // does not make room for the allocation until the next cycle.
  assign alloc_acc = AllocValid & ~TrkFull & ~Flush;
  assign alloc_ovf = AllocValid &  TrkFull & ~Flush;

  // done must already be registered, so a head completing in cycle N
  // releases at the earliest in N+1.
  assign rel_go = ent_q[head_q].valid & ent_q[head_q].done & CommitEn & ~Flush;

  assign count_d = count_q + {{PTRW{1'b0}}, alloc_acc} - {{PTRW{1'b0}}, rel_go};

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      for (int i = 0; i < TRKDEEP; i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rel_valid_q <= 1'b0;
      rel_tag_q   <= '0;
      ovf_q       <= 1'b0;
    end else if (Flush) begin
      // Tags are not returned: the free list reinitialises itself on clean.
      for (int i = 0; i < TRKDEEP; i++) ent_q[i].valid <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rel_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < TRKDEEP; i++) begin
        if (match_vec[i]) ent_q[i].done <= 1'b1;
      end
      if (rel_go) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
        rel_tag_q           <= ent_q[head_q].tag;
      end
      // Accepted allocation never targets head while head is valid, since
      // tail only reaches a valid head when the tracker is full.
      if (alloc_acc) begin
        ent_q[tail_q] <= '{valid: 1'b1, done: 1'b0, tag: AllocTag};
        tail_q        <= tail_q + 1'b1;
      end
      count_q     <= count_d;
      rel_valid_q <= rel_go;
      if (alloc_ovf) ovf_q <= 1'b1;
    end
  end

  assign RelValid = rel_valid_q;
  assign RelTag   = rel_tag_q;
  assign OvfErr   = ovf_q;

endmodule
